imm_sel_ctrl: RTL and testbench
===============================

# imm_sel_ctrl

Decode-stage controller that feeds the immediate generator in the RV32I core. It accepts 32-bit instructions from fetch over a valid/ready handshake and decodes the opcode into the one-hot immediate-type selects. It registers the instruction bits [31:7] together with the selects, presents them to the immediate generator and execute stage, and flags illegal encodings. A 2-entry elastic buffer (output register plus skid register) gives full throughput under execute back-pressure; `flush_i` squashes both entries.

## Interface
- `XLEN`, 32: instruction/datapath width; only 32 is supported.
- `clk_i` input 1: clock; all state updates on rising edge.
- `rst_i` input 1: reset. Synchronous, active-high.
- `if_valid_i` input 1: fetch presents an instruction.
- `if_ready_o` output 1: block can accept; registered.
- `inst_i` input 32: instruction word.
- `flush_i` input 1: squash all buffered instructions (branch/jump redirect).
- `id_valid_o` output 1: output register holds a valid instruction.
- `ex_ready_i` input 1: downstream accepts the output this cycle.
- `id_inst_o` output 25: registered `inst[31:7]`, drives the immediate generator's instruction input.
- `IMM_I_type_1_o`, `IMM_I_type_2_o`, `IMM_S_type_o`, `IMM_B_type_o`, `IMM_U_type_o`, `IMM_J_type_o` output 1 each: registered one-hot immediate selects.
- `illegal_o` output 1: registered; output entry is an illegal encoding.

## Operation
- Decode is applied to `inst_i` before storage. Both entries hold {inst[31:7], 6 selects, illegal}.
- `inst[1:0]` != 2'b11 → illegal.
- Opcodes LOAD 0000011, JALR 1100111 (funct3 must be 000): I_type_1.
- OP-IMM 0010011:
  - funct3 001 or 101 → I_type_2.
  - funct3 001 with funct7 != 0000000 → illegal.
  - funct3 101 with funct7 not in {0000000, 0100000} → illegal.
  - All other funct3 → I_type_1.
- STORE 0100011 → S. BRANCH 1100011 → B. LUI 0110111 and AUIPC 0010111 → U. JAL 1101111 → J.
- OP 0110011, MISC-MEM 0001111, SYSTEM 1110011: all selects 0, legal.
- Any other opcode → illegal.
- When `illegal_o`=1, all six selects are 0. At most one select is ever 1.
- `id_inst_o` and selects are held stable while `id_valid_o`=1 and `ex_ready_i`=0.

## Timing
- Reset: `id_valid_o`=0, skid empty, `if_ready_o`=1, `id_inst_o`=0, all selects 0, `illegal_o`=0.
- Accept = `if_valid_i` & `if_ready_o`. Transfer = `id_valid_o` & `ex_ready_i`.
- Latency: an instruction accepted in cycle N appears on `id_valid_o` in N+1 if the output register is free or transferring.
- Throughput: 1 instruction per cycle with `ex_ready_i` held high.
- Output register free = !`id_valid_o` | transfer. When free, it loads from the skid register if the skid is valid, else from the input if an accept occurs, else it clears valid.
- An accept while the output register is not free writes the skid register.
- The skid valid clears when it moves into the output register.
- `if_ready_o` next = !skid_valid_next. It drops the cycle after the skid fills, so no instruction is ever lost.
- An accept with the skid loading into the output register in the same cycle puts the new instruction into the skid. Ordering is preserved.
- `flush_i`=1:
  - Next cycle, `id_valid_o`=0, skid empty, `if_ready_o`=1.
  - An instruction presented in the flush cycle is discarded, even if accepted.
  - A transfer in the flush cycle still completes downstream.
- `rst_i` takes priority over `flush_i` and over all handshakes. Mid-stream reset yields the reset state next cycle.

## Structure
- Shared package `rv32i_pkg` holds the opcode constants (OPC_LOAD, OPC_OP_IMM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM), funct3 SLLI/SRLI values and the 7-bit entry-field widths.
- Sub-module `imm_sel_dec`: purely combinational inst → {6 selects, illegal}, instanced once on the input path.
- Top level holds the two entries and the handshake logic.

## Test plan
- Reset, then single instructions with `ex_ready_i`=1:
  - 0x00500093 (addi) → 1 cycle later `id_valid_o`=1, `IMM_I_type_1_o`=1, `id_inst_o`=0x00500093>>7.
  - 0x00309093 (slli) → `IMM_I_type_2_o`=1.
  - 0x0020A423 (sw) → `IMM_S_type_o`=1.
  - 0x00000463 (beq) → `IMM_B_type_o`=1.
  - 0x123450B7 (lui) → `IMM_U_type_o`=1.
  - 0x008000EF (jal) → `IMM_J_type_o`=1.
- Illegal words:
  - 0x00000000 → `illegal_o`=1, all selects 0.
  - 0x40309093 (slli, bad funct7) → `illegal_o`=1.
  - 0x00000033 (add) → legal, all selects 0.
- Back-pressure: stream 4 instructions, `ex_ready_i`=0 for 3 cycles.
  - `if_ready_o` falls exactly after the 2nd accept.
  - Output held stable.
  - On release, all 4 are delivered in order with no duplicates.
- Flush while both entries are full and `if_valid_i`=1: next cycle `id_valid_o`=0, `if_ready_o`=1; neither the buffered nor the flush-cycle instruction ever appears.
- Assert `rst_i` mid-stream with the skid full: next cycle all outputs are at reset values; the first post-reset accept emerges 1 cycle later.
- Random valid/ready/flush traffic against a scoreboard: order preserved, no loss or duplication, one-hot/illegal invariant holds every cycle.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode constants and the entry layout used by the decode-stage
// immediate-select controller.
//   - opcode constants, funct3 shift-immediate values, funct7 shift forms
//   - entry field widths and the packed select/entry structs
package rv32i_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRLI = 3'b101;  // shared by SRLI/SRAI
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Entry fields: inst[31:7], six selects, illegal flag.
  localparam int ENT_INST_W = 25;
  localparam int ENT_SEL_W  = 6;

  typedef struct packed {
    logic i1;
    logic i2;
    logic s;
    logic b;
    logic u;
    logic j;
  } sel_t;

  typedef struct packed {
    logic [ENT_INST_W-1:0] inst;
    sel_t                  sel;
    logic                  illegal;
  } entry_t;

endpackage

// File: rtl/imm_sel_ctrl_if.sv
// Fetch/execute-facing bus of imm_sel_ctrl.
//   slave  : the controller's view (accepts from fetch, drives execute)
//   master : the environment's view
interface imm_sel_ctrl_if;
  logic        if_valid_i;
  logic        if_ready_o;
  logic [31:0] inst_i;
  logic        flush_i;
  logic        id_valid_o;
  logic        ex_ready_i;
  logic [24:0] id_inst_o;
  logic        IMM_I_type_1_o;
  logic        IMM_I_type_2_o;
  logic        IMM_S_type_o;
  logic        IMM_B_type_o;
  logic        IMM_U_type_o;
  logic        IMM_J_type_o;
  logic        illegal_o;

  modport slave (
    input  if_valid_i, inst_i, flush_i, ex_ready_i,
    output if_ready_o, id_valid_o, id_inst_o,
           IMM_I_type_1_o, IMM_I_type_2_o, IMM_S_type_o,
           IMM_B_type_o, IMM_U_type_o, IMM_J_type_o, illegal_o
  );

  modport master (
    output if_valid_i, inst_i, flush_i, ex_ready_i,
    input  if_ready_o, id_valid_o, id_inst_o,
           IMM_I_type_1_o, IMM_I_type_2_o, IMM_S_type_o,
           IMM_B_type_o, IMM_U_type_o, IMM_J_type_o, illegal_o
  );
endinterface

// File: rtl/imm_sel_ctrl_dec.sv
// imm_sel_dec: combinational opcode decode into one-hot immediate selects.
//   opcode/funct3/funct7 : instruction fields
//   sel                  : at most one bit set; all zero when illegal
//   illegal              : unsupported or malformed encoding
module imm_sel_dec
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output sel_t       sel,
  output logic       illegal
);
  sel_t sel_raw;
  logic bad;

  always_comb begin
    sel_raw = '0;
    bad     = 1'b0;
    unique case (opcode)
      OPC_LOAD:   sel_raw.i1 = 1'b1;
      OPC_JALR:   if (funct3 == 3'b000) sel_raw.i1 = 1'b1; else bad = 1'b1;
      OPC_OP_IMM: begin
        if (funct3 == F3_SLLI) begin
          sel_raw.i2 = 1'b1;
          bad        = (funct7 != F7_BASE);
        end else if (funct3 == F3_SRLI) begin
          sel_raw.i2 = 1'b1;
          bad        = (funct7 != F7_BASE) && (funct7 != F7_ALT);
        end else begin
          sel_raw.i1 = 1'b1;
        end
      end
      OPC_STORE:               sel_raw.s = 1'b1;
      OPC_BRANCH:              sel_raw.b = 1'b1;
      OPC_LUI, OPC_AUIPC:      sel_raw.u = 1'b1;
      OPC_JAL:                 sel_raw.j = 1'b1;
      OPC_OP, OPC_MISC_MEM,
      OPC_SYSTEM:              ;  // legal, no immediate
      default:                 bad = 1'b1;
    endcase
    // Compressed-space words are never valid here, whatever the opcode.
    if (opcode[1:0] != 2'b11) bad = 1'b1;
  end

  assign illegal = bad;
  assign sel     = bad ? '0 : sel_raw;
endmodule

// File: rtl/imm_sel_ctrl.sv
// imm_sel_ctrl: decode-stage controller for the immediate generator.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : fetch valid/ready + inst, flush, execute valid/ready,
//                  registered inst[31:7], one-hot selects, illegal flag
// Two-entry elastic buffer: output register plus skid register. Ready is
// registered and equals !skid_valid, so an accept can only ever land in an
// empty slot.
module imm_sel_ctrl
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  imm_sel_ctrl_if.slave   bus
);
  logic [XLEN-1:0] inst_in;
  entry_t          in_ent, out_q, out_d, skid_q, skid_d;
  logic            out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, rdy_q;
  logic            accept, xfer, out_free;

  assign inst_in = bus.inst_i;

  imm_sel_dec u_dec (
    .opcode  (inst_in[6:0]),
    .funct3  (inst_in[14:12]),
    .funct7  (inst_in[31:25]),
    .sel     (in_ent.sel),
    .illegal (in_ent.illegal)
  );
  assign in_ent.inst = inst_in[31:7];

  assign accept   = bus.if_valid_i & rdy_q;
  assign xfer     = out_vld_q & bus.ex_ready_i;
  assign out_free = ~out_vld_q | xfer;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (bus.flush_i) begin
      // Squash both entries and anything accepted this cycle; a transfer
      // in this cycle has already been taken by execute.
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (out_free) begin
      if (skid_vld_q) begin
        out_d      = skid_q;
        out_vld_d  = 1'b1;
        skid_vld_d = accept;  // new word queues behind the promoted one
        if (accept) skid_d = in_ent;
      end else begin
        out_vld_d = accept;
        if (accept) out_d = in_ent;
      end
    end else if (accept) begin
      skid_d     = in_ent;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= ~skid_vld_d;
    end
  end

  assign bus.if_ready_o     = rdy_q;
  assign bus.id_valid_o     = out_vld_q;
  assign bus.id_inst_o      = out_q.inst;
  assign bus.IMM_I_type_1_o = out_q.sel.i1;
  assign bus.IMM_I_type_2_o = out_q.sel.i2;
  assign bus.IMM_S_type_o   = out_q.sel.s;
  assign bus.IMM_B_type_o   = out_q.sel.b;
  assign bus.IMM_U_type_o   = out_q.sel.u;
  assign bus.IMM_J_type_o   = out_q.sel.j;
  assign bus.illegal_o      = out_q.illegal;
endmodule

// File: tb/tb_imm_sel_ctrl.sv
module tb_imm_sel_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imm_sel_ctrl_if bus ();

  imm_sel_ctrl #(.XLEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Directed table: word and hand-decoded {i1,i2,s,b,u,j,illegal}.
  localparam int NV = 18;
  logic [31:0] vec_inst [NV] = '{
    32'h00500093, 32'h00309093, 32'h0020A423, 32'h00000463, 32'h123450B7,
    32'h008000EF, 32'h00000000, 32'h40309093, 32'h00000033, 32'h40505093,
    32'h00008067, 32'h00001067, 32'h00000012, 32'h00000097, 32'h00002083,
    32'h0000000B, 32'hC0005093, 32'h0000000F };
  logic [6:0] vec_flg [NV] = '{
    7'b1000000, 7'b0100000, 7'b0010000, 7'b0001000, 7'b0000100,
    7'b0000010, 7'b0000001, 7'b0000001, 7'b0000000, 7'b0100000,
    7'b1000000, 7'b0000001, 7'b0000001, 7'b0000100, 7'b1000000,
    7'b0000001, 7'b0000001, 7'b0000000 };

  function automatic logic [6:0] flags();
    return {bus.IMM_I_type_1_o, bus.IMM_I_type_2_o, bus.IMM_S_type_o,
            bus.IMM_B_type_o, bus.IMM_U_type_o, bus.IMM_J_type_o, bus.illegal_o};
  endfunction

  // Transfers seen by execute, recorded mid-cycle.
  logic [24:0] delivered [$];
  always @(negedge clk)
    if (!rst && bus.id_valid_o && bus.ex_ready_i) delivered.push_back(bus.id_inst_o);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
    bus.if_valid_i = v;
    bus.inst_i     = w;
    bus.ex_ready_i = rdy;
    bus.flush_i    = fl;
  endtask

  logic [31:0] a, b, c, d;
  int          sb [$];
  int          idx;
  logic        acc, xf, fl;

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_id_valid", 32'(bus.id_valid_o), 0);
    chk("rst_if_ready", 32'(bus.if_ready_o), 1);
    chk("rst_id_inst",  32'(bus.id_inst_o), 0);
    chk("rst_flags",    32'(flags()), 0);

    // Single instructions, execute always ready.
    for (int i = 0; i < NV; i++) begin
      drive(1, vec_inst[i], 1, 0);
      tick();
      drive(0, 0, 1, 0);
      chk($sformatf("single%0d_valid", i), 32'(bus.id_valid_o), 1);
      chk($sformatf("single%0d_inst", i),  32'(bus.id_inst_o), vec_inst[i] >> 7);
      chk($sformatf("single%0d_flags", i), 32'(flags()), 32'(vec_flg[i]));
      tick();
      chk($sformatf("single%0d_drain", i), 32'(bus.id_valid_o), 0);
    end

    // Back-pressure: ex_ready low for 3 cycles while streaming 4 words.
    a = vec_inst[0]; b = vec_inst[1]; c = vec_inst[2]; d = vec_inst[3];
    delivered.delete();
    drive(1, a, 0, 0); tick();
    chk("bp_ready_after1", 32'(bus.if_ready_o), 1);
    drive(1, b, 0, 0); tick();
    chk("bp_ready_after2", 32'(bus.if_ready_o), 0);
    chk("bp_hold1", 32'(bus.id_inst_o), a >> 7);
    drive(1, c, 0, 0); tick();
    chk("bp_hold2", 32'(bus.id_inst_o), a >> 7);
    chk("bp_hold2_flags", 32'(flags()), 32'(vec_flg[0]));
    drive(1, c, 1, 0); tick();           // not accepted: ready was low
    chk("bp_out_b", 32'(bus.id_inst_o), b >> 7);
    drive(1, c, 1, 0); tick();
    drive(1, d, 1, 0); tick();
    drive(0, 0, 1, 0); tick(); tick();
    chk("bp_count", 32'(delivered.size()), 4);
    if (delivered.size() == 4) begin
      chk("bp_ord0", 32'(delivered[0]), a >> 7);
      chk("bp_ord1", 32'(delivered[1]), b >> 7);
      chk("bp_ord2", 32'(delivered[2]), c >> 7);
      chk("bp_ord3", 32'(delivered[3]), d >> 7);
    end

    // Flush with both entries full and a word presented.
    delivered.delete();
    drive(1, vec_inst[4], 0, 0); tick();
    drive(1, vec_inst[5], 0, 0); tick();
    chk("fl_full", 32'(bus.if_ready_o), 0);
    drive(1, vec_inst[6], 0, 1); tick();
    drive(0, 0, 1, 0);
    chk("fl_valid", 32'(bus.id_valid_o), 0);
    chk("fl_ready", 32'(bus.if_ready_o), 1);
    tick(); tick();
    chk("fl_nothing", 32'(delivered.size()), 0);

    // Flush with a transfer and an accept in the same cycle.
    drive(1, vec_inst[7], 0, 0); tick();
    drive(1, vec_inst[8], 1, 1); tick();
    drive(0, 0, 1, 0);
    chk("fl2_valid", 32'(bus.id_valid_o), 0);
    chk("fl2_ready", 32'(bus.if_ready_o), 1);
    tick(); tick();
    chk("fl2_count", 32'(delivered.size()), 1);
    if (delivered.size() == 1) chk("fl2_xfer", 32'(delivered[0]), vec_inst[7] >> 7);

    // Reset mid-stream with the skid full.
    drive(1, vec_inst[9], 0, 0); tick();
    drive(1, vec_inst[10], 0, 0); tick();
    chk("rs_full", 32'(bus.if_ready_o), 0);
    rst = 1'b1;
    drive(1, vec_inst[11], 0, 1); tick();
    rst = 1'b0;
    chk("rs_valid", 32'(bus.id_valid_o), 0);
    chk("rs_ready", 32'(bus.if_ready_o), 1);
    chk("rs_inst",  32'(bus.id_inst_o), 0);
    chk("rs_flags", 32'(flags()), 0);
    drive(1, vec_inst[13], 1, 0); tick();
    drive(0, 0, 1, 0);
    chk("rs_first_valid", 32'(bus.id_valid_o), 1);
    chk("rs_first_inst",  32'(bus.id_inst_o), vec_inst[13] >> 7);
    tick();

    // Random traffic against a scoreboard of table indices.
    sb.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      idx = $urandom_range(NV - 1);
      fl  = ($urandom_range(15) == 0);
      drive($urandom_range(3) != 0, vec_inst[idx], $urandom_range(2) != 0, fl);
      @(negedge clk);
      acc = bus.if_valid_i & bus.if_ready_o;
      xf  = bus.id_valid_o & bus.ex_ready_i;
      if (bus.id_valid_o) begin
        chk("rnd_onehot", 32'($countones(flags()) <= 1), 1);
      end
      if (xf) begin
        if (sb.size() == 0) chk("rnd_underflow", 32'(sb.size()), 1);
        else begin
          chk("rnd_inst",  32'(bus.id_inst_o), vec_inst[sb[0]] >> 7);
          chk("rnd_flags", 32'(flags()), 32'(vec_flg[sb[0]]));
          void'(sb.pop_front());
        end
      end
      if (fl) sb.delete();
      else if (acc) sb.push_back(idx);
      tick();
    end
    drive(0, 0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.id_valid_o && sb.size() != 0) begin
        chk("drain_inst", 32'(bus.id_inst_o), vec_inst[sb[0]] >> 7);
        void'(sb.pop_front());
      end
      tick();
    end
    chk("rnd_left", 32'(sb.size()), 0);
    chk("rnd_idle", 32'(bus.id_valid_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
